// File: rtl/xloader_pkg.sv
// Shared loader definitions: reboot FSM state encodings and default unlock key bytes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xloader_pkg;

  // Encoding is visible on the debug port, so the values are pinned explicitly.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIRE  = 2'd3
  } state_e;

  // Default unlock bytes; the host-side command tables use the same values.
  localparam logic [7:0] KEY0_DEFAULT = 8'h5A;
  localparam logic [7:0] KEY1_DEFAULT = 8'hA5;

  // Command bytes are only taken while the unlock sequence can still progress.
  function automatic logic cmd_accepting(input state_e s);
    return (s == ST_IDLE) || (s == ST_ARMED);
  endfunction

endpackage

// File: rtl/reboot_timer.sv
// Saturating up-counter with synchronous clear/enable and an expiry flag at LIMIT-1.
// Latency: count updates one cycle after en; expired_o is decoded from the count register.
// Backpressure: none; clear has priority over enable, count sticks at LIMIT.
module reboot_timer #(
  parameter int LIMIT = 64,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_o
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] MAX  = W'(LIMIT);

  logic [W-1:0] count_q, count_d;

  // Clear wins; otherwise count up and hold at MAX so the value never wraps.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q >= LAST);

endmodule

// File: rtl/reboot_ctrl.sv
// Key-protected reboot request: KEY0,KEY1 within ARM_TIMEOUT, then QUIET_CYCLES idle busy_in, then sticky reboot.
// Latency: state/reboot/abort registered; reboot rises 1+QUIET_CYCLES cycles after KEY1 when busy_in stays low.
// Backpressure: cmd_ready high only in IDLE/ARMED; REBOOT_CTRL_WDT_EN adds an idle watchdog that forces DRAIN.
module reboot_ctrl
  import xloader_pkg::*;
#(
  parameter logic [7:0] KEY0         = KEY0_DEFAULT,
  parameter logic [7:0] KEY1         = KEY1_DEFAULT,
  parameter int         ARM_TIMEOUT  = 1024,
  parameter int         QUIET_CYCLES = 64,
  parameter int         WDT_CYCLES   = 1 << 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       busy_in,
  output logic       reboot,
  output logic       abort_o,
  output logic [1:0] state_o
);

  state_e state_q, state_d;
  logic   reboot_q, reboot_d;
  logic   abort_q, abort_d;
  logic   accept;
  logic   arm_expired;
  logic   quiet_expired;
  logic   wdt_fire;

  assign cmd_ready = cmd_accepting(state_q);
  assign accept    = cmd_valid & cmd_ready;

  // Arm window: runs only while ARMED; any accepted byte restarts it (a repeated KEY0 re-arms).
  reboot_timer #(.LIMIT(ARM_TIMEOUT)) u_arm_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       ((state_q != ST_ARMED) | accept),
    .en        (state_q == ST_ARMED),
    .expired_o (arm_expired)
  );

  // Quiet window: any busy cycle in DRAIN restarts the full window.
  reboot_timer #(.LIMIT(QUIET_CYCLES)) u_quiet_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       ((state_q != ST_DRAIN) | busy_in),
    .en        ((state_q == ST_DRAIN) & ~busy_in),
    .expired_o (quiet_expired)
  );

`ifdef REBOOT_CTRL_WDT_EN
  logic wdt_expired;

  // Idle watchdog: held at zero outside IDLE, restarted by every accepted byte.
  reboot_timer #(.LIMIT(WDT_CYCLES)) u_wdt_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       ((state_q != ST_IDLE) | accept),
    .en        (state_q == ST_IDLE),
    .expired_o (wdt_expired)
  );

  // A byte arriving on the expiry cycle counts as activity and suppresses the forced reboot.
  assign wdt_fire = (state_q == ST_IDLE) & wdt_expired & ~accept;
`else
  logic wdt_unused;

  assign wdt_fire   = 1'b0;
  assign wdt_unused = (WDT_CYCLES == 0);
`endif

  // Next-state and output decode; KEY1 beats a coincident arm expiry.
  always_comb begin
    state_d = state_q;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && (cmd_data == KEY0)) begin
          state_d = ST_ARMED;
        end else if (wdt_fire) begin
          state_d = ST_DRAIN;
        end
      end
      ST_ARMED: begin
        if (accept) begin
          if (cmd_data == KEY1) begin
            state_d = ST_DRAIN;
          end else if (cmd_data != KEY0) begin
            state_d = ST_IDLE;
            abort_d = 1'b1;
          end
        end else if (arm_expired) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!busy_in && quiet_expired) begin
          state_d = ST_FIRE;
        end
      end
      ST_FIRE: begin
        state_d = ST_FIRE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    reboot_d = reboot_q | (state_d == ST_FIRE);
  end

  // FSM state and registered outputs; reset drops reboot immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      reboot_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      reboot_q <= reboot_d;
      abort_q  <= abort_d;
    end
  end

  assign reboot  = reboot_q;
  assign abort_o = abort_q;
  assign state_o = state_q;

endmodule
